// File: rtl/xmul_pkg.sv
// Shared definitions for the extended multiplier pipeline.
// Holds the 6-bit function codes, the decode-vector constants
// {cmd_hi, lhs_signed, rhs_signed, acc}, the default tag width and
// the decode helper used by xmul_core.
package xmul_pkg;

   localparam int unsigned FNW      = 6;
   localparam int unsigned TAGW_DEF = 5;

   // Function codes
   localparam logic [FNW-1:0] FN_MUL    = 6'd0;
   localparam logic [FNW-1:0] FN_MULH   = 6'd1;
   localparam logic [FNW-1:0] FN_MULHSU = 6'd2;
   localparam logic [FNW-1:0] FN_MULHU  = 6'd3;
   localparam logic [FNW-1:0] FN_MADDL  = 6'd50;
   localparam logic [FNW-1:0] FN_MADDH  = 6'd51;

   // Decode vectors {cmd_hi, lhs_signed, rhs_signed, acc}
   localparam logic [3:0] DEC_MUL    = 4'b0000;
   localparam logic [3:0] DEC_MULH   = 4'b1110;
   localparam logic [3:0] DEC_MULHSU = 4'b1100;
   localparam logic [3:0] DEC_MULHU  = 4'b1000;
   localparam logic [3:0] DEC_MADDL  = 4'b0001;
   localparam logic [3:0] DEC_MADDH  = 4'b1001;
   localparam logic [3:0] DEC_NONE   = 4'b0000;

   // Decoded control carried down the pipe; legal=0 forces a zero result
   typedef struct packed {
      logic legal;
      logic cmd_hi;
      logic lhs_signed;
      logic rhs_signed;
      logic acc;
   } dec_t;

   // Map a function code to its control vector; unknown codes decode to an all-zero, illegal vector
   function automatic dec_t decode_fn(input logic [FNW-1:0] fn);
      dec_t       d;
      logic [3:0] v;
      v       = DEC_NONE;
      d.legal = 1'b1;
      case (fn)
         FN_MUL:    v = DEC_MUL;
         FN_MULH:   v = DEC_MULH;
         FN_MULHSU: v = DEC_MULHSU;
         FN_MULHU:  v = DEC_MULHU;
         FN_MADDL:  v = DEC_MADDL;
         FN_MADDH:  v = DEC_MADDH;
         default: begin
            v       = DEC_NONE;
            d.legal = 1'b0;
         end
      endcase
      d.cmd_hi     = v[3];
      d.lhs_signed = v[2];
      d.rhs_signed = v[1];
      d.acc        = v[0];
      return d;
   endfunction

endpackage

// File: rtl/xmul_core.sv
// Combinational heart of the extended multiplier.
// Two independent paths:
//   - request-side decode of the function code (registered by the pipe)
//   - XLEN+1 signed multiply of the registered operands and the result mux
//     (MUL / MULH* / MADDL low limb / MADDH high limb, accumulate excluded)
// Ports:
//   req_fn    in   function code of the incoming request
//   req_dec   out  decoded control for req_fn
//   op_dec    in   registered decoded control
//   op_dw     in   registered word/doubleword select (MUL with XLEN=64 only)
//   op_in1    in   registered multiplicand
//   op_in2    in   registered multiplier
//   prod_sel  out  selected product field, before the in3 accumulate
module xmul_core
   import xmul_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned RADIX = 51
) (
   input  logic [FNW-1:0]  req_fn,
   output dec_t            req_dec,
   input  dec_t            op_dec,
   input  logic            op_dw,
   input  logic [XLEN-1:0] op_in1,
   input  logic [XLEN-1:0] op_in2,
   output logic [XLEN-1:0] prod_sel
);

   localparam int unsigned PW = 2 * XLEN + 2;
   localparam logic [XLEN-1:0] LO_MASK = {XLEN{1'b1}} >> (XLEN - RADIX);

   logic signed [XLEN:0]   lhs;
   logic signed [XLEN:0]   rhs;
   logic signed [PW-1:0]   prod;
   logic [XLEN-1:0]        word_res;
   logic                   unused_prod_hi;

   assign req_dec = decode_fn(req_fn);

   // Operand extension, full-width product and field select
   always_comb begin
      lhs            = $signed({op_dec.lhs_signed & op_in1[XLEN-1], op_in1});
      rhs            = $signed({op_dec.rhs_signed & op_in2[XLEN-1], op_in2});
      prod           = PW'(lhs) * PW'(rhs);
      word_res       = XLEN'($signed(prod[31:0]));
      unused_prod_hi = ^prod[PW-1:2*XLEN];
      prod_sel       = '0;
      if (op_dec.legal) begin
         if (op_dec.acc) begin
            // MADDH takes the limb above RADIX, MADDL the zero-extended low limb
            if (op_dec.cmd_hi)
               prod_sel = prod[RADIX+XLEN-1:RADIX];
            else
               prod_sel = prod[XLEN-1:0] & LO_MASK;
         end else if (op_dec.cmd_hi) begin
            prod_sel = prod[2*XLEN-1:XLEN];
         end else if ((XLEN == 64) && !op_dw) begin
            // 32-bit word MUL result is sign-extended to the full width
            prod_sel = word_res;
         end else begin
            prod_sel = prod[XLEN-1:0];
         end
      end
   end

endmodule

// File: rtl/xmul_pipe.sv
// Pipelined extended multiplier with valid/ready on both sides.
// Stage 1 holds operands, decoded control, tag and in3; the remaining
// STAGES-1 registers carry the selected product, in3 and the accumulate
// flag. The in3 add sits after the last register. A single enable
// (output empty or being consumed) advances or freezes every stage.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   req_valid/req_ready  request handshake (req_ready = pipe enable)
//   req_bits_dw          1 = full XLEN, 0 = 32-bit word MUL (XLEN=64)
//   req_bits_fn          function code
//   req_bits_tag         destination tag
//   req_bits_in1/in2     multiplicand / multiplier
//   req_in3              accumuland for MADDL/MADDH
//   resp_valid/ready     response handshake
//   resp_data/resp_tag   result and its tag
module xmul_pipe
   import xmul_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned RADIX  = 51,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAGW   = TAGW_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_bits_dw,
   input  logic [FNW-1:0]  req_bits_fn,
   input  logic [TAGW-1:0] req_bits_tag,
   input  logic [XLEN-1:0] req_bits_in1,
   input  logic [XLEN-1:0] req_bits_in2,
   input  logic [XLEN-1:0] req_in3,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [TAGW-1:0] resp_tag
);

   // Registers after the operand stage; the last one feeds the output
   localparam int unsigned PS = STAGES - 1;

   logic            en;
   dec_t            req_dec;
   logic [XLEN-1:0] core_prod;

   logic            s1_valid;
   logic [TAGW-1:0] s1_tag;
   dec_t            s1_dec;
   logic            s1_dw;
   logic [XLEN-1:0] s1_in1;
   logic [XLEN-1:0] s1_in2;
   logic [XLEN-1:0] s1_in3;

   logic            p_valid [PS];
   logic [TAGW-1:0] p_tag   [PS];
   logic [XLEN-1:0] p_prod  [PS];
   logic [XLEN-1:0] p_in3   [PS];
   logic            p_acc   [PS];

   xmul_core #(
      .XLEN  (XLEN),
      .RADIX (RADIX)
   ) u_core (
      .req_fn   (req_bits_fn),
      .req_dec  (req_dec),
      .op_dec   (s1_dec),
      .op_dw    (s1_dw),
      .op_in1   (s1_in1),
      .op_in2   (s1_in2),
      .prod_sel (core_prod)
   );

   // Shared stall: the whole pipe freezes while an unconsumed result sits at the output
   assign en        = !resp_valid || resp_ready;
   assign req_ready = en;

   // Operand stage and product/result stages; data only loads behind a valid
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
         s1_dec   <= '0;
         s1_dw    <= 1'b0;
         s1_in1   <= '0;
         s1_in2   <= '0;
         s1_in3   <= '0;
         for (int unsigned i = 0; i < PS; i++) begin
            p_valid[i] <= 1'b0;
            p_tag[i]   <= '0;
            p_prod[i]  <= '0;
            p_in3[i]   <= '0;
            p_acc[i]   <= 1'b0;
         end
      end else if (en) begin
         s1_valid <= req_valid;
         if (req_valid) begin
            s1_tag <= req_bits_tag;
            s1_dec <= req_dec;
            s1_dw  <= req_bits_dw;
            s1_in1 <= req_bits_in1;
            s1_in2 <= req_bits_in2;
            s1_in3 <= req_in3;
         end
         p_valid[0] <= s1_valid;
         if (s1_valid) begin
            p_tag[0]  <= s1_tag;
            p_prod[0] <= core_prod;
            p_in3[0]  <= s1_in3;
            p_acc[0]  <= s1_dec.legal & s1_dec.acc;
         end
         for (int unsigned i = 1; i < PS; i++) begin
            p_valid[i] <= p_valid[i-1];
            if (p_valid[i-1]) begin
               p_tag[i]  <= p_tag[i-1];
               p_prod[i] <= p_prod[i-1];
               p_in3[i]  <= p_in3[i-1];
               p_acc[i]  <= p_acc[i-1];
            end
         end
      end
   end

   // Accumulate after the final register; wraps mod 2^XLEN
   assign resp_valid = p_valid[PS-1];
   assign resp_tag   = p_tag[PS-1];
   assign resp_data  = p_prod[PS-1] + (p_acc[PS-1] ? p_in3[PS-1] : '0);

endmodule

// File: tb/tb_xmul_pipe.sv
`timescale 1ns/1ps
module tb_xmul_pipe;
   import xmul_pkg::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   // XLEN=64, RADIX=51, STAGES=2
   logic        a_req_valid, a_req_ready, a_dw, a_resp_valid, a_resp_ready;
   logic [5:0]  a_fn;
   logic [4:0]  a_tag, a_rtag;
   logic [63:0] a_in1, a_in2, a_in3, a_data;
   // XLEN=32, RADIX=26, STAGES=4
   logic        b_req_valid, b_req_ready, b_dw, b_resp_valid, b_resp_ready;
   logic [5:0]  b_fn;
   logic [4:0]  b_tag, b_rtag;
   logic [31:0] b_in1, b_in2, b_in3, b_data;

   xmul_pipe #(.XLEN(64), .RADIX(51), .STAGES(2), .TAGW(5)) dut64 (
      .clock(clock), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_bits_dw(a_dw), .req_bits_fn(a_fn), .req_bits_tag(a_tag),
      .req_bits_in1(a_in1), .req_bits_in2(a_in2), .req_in3(a_in3),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_data), .resp_tag(a_rtag));

   xmul_pipe #(.XLEN(32), .RADIX(26), .STAGES(4), .TAGW(5)) dut32 (
      .clock(clock), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_bits_dw(b_dw), .req_bits_fn(b_fn), .req_bits_tag(b_tag),
      .req_bits_in1(b_in1), .req_bits_in2(b_in2), .req_in3(b_in3),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_data), .resp_tag(b_rtag));

   typedef struct {
      logic [63:0] data;
      logic [4:0]  tag;
      int          exp_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_total = 0;
   int   n_pass  = 0;
   int   cyc     = 0;
   bit   mon_on  = 1'b1;
   int   stall_checks = 0;
   logic        a_held_v = 1'b0;
   logic [63:0] a_hd;
   logic [4:0]  a_ht;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   // Monitor for the 64-bit unit: stall stability plus in-order scoreboard
   always @(negedge clock) begin
      if (a_held_v) begin
         check("a stall data stable", a_data, a_hd);
         check("a stall tag stable", 64'(a_rtag), 64'(a_ht));
         stall_checks++;
      end
      a_held_v = 1'b0;
      if (mon_on && a_resp_valid) begin
         if (!a_resp_ready) begin
            check("a req_ready during stall", 64'(a_req_ready), 64'd0);
            a_held_v = 1'b1;
            a_hd     = a_data;
            a_ht     = a_rtag;
         end else if (qa.size() == 0) begin
            n_total++;
            $display("FAIL a unexpected response: tag %0d data 0x%h, expected none", a_rtag, a_data);
         end else begin
            ea = qa.pop_front();
            check("a data", a_data, ea.data);
            check("a tag", 64'(a_rtag), 64'(ea.tag));
            if (ea.chk_lat) check("a latency", 64'(cyc), 64'(ea.exp_cyc));
         end
      end
   end

   // Monitor for the 32-bit unit
   always @(negedge clock) begin
      if (mon_on && b_resp_valid && b_resp_ready) begin
         if (qb.size() == 0) begin
            n_total++;
            $display("FAIL b unexpected response: tag %0d data 0x%h, expected none", b_rtag, b_data);
         end else begin
            eb = qb.pop_front();
            check("b data", 64'(b_data), eb.data);
            check("b tag", 64'(b_rtag), 64'(eb.tag));
            if (eb.chk_lat) check("b latency", 64'(cyc), 64'(eb.exp_cyc));
         end
      end
   end

   // Drive one request and hold it until accepted; expected result goes to the scoreboard
   task automatic send(input bit b, input logic [5:0] fn, input logic dw, input logic [4:0] tag,
                       input logic [63:0] in1, input logic [63:0] in2, input logic [63:0] in3,
                       input logic [63:0] exp, input bit chk_lat, input bit push);
      int   waited = 0;
      exp_t e;
      @(posedge clock); #1;
      if (b) begin
         a_req_valid = 1'b0;
         b_req_valid = 1'b1; b_fn = fn; b_dw = dw; b_tag = tag;
         b_in1 = in1[31:0]; b_in2 = in2[31:0]; b_in3 = in3[31:0];
      end else begin
         b_req_valid = 1'b0;
         a_req_valid = 1'b1; a_fn = fn; a_dw = dw; a_tag = tag;
         a_in1 = in1; a_in2 = in2; a_in3 = in3;
      end
      @(negedge clock);
      while (!(b ? b_req_ready : a_req_ready)) begin
         waited++;
         if (waited > 50) begin
            n_total++;
            $display("FAIL send timeout: req_ready 0 for tag %0d, expected 1", tag);
            return;
         end
         @(negedge clock);
      end
      if (push) begin
         e.data    = exp;
         e.tag     = tag;
         e.exp_cyc = cyc + (b ? 4 : 2);
         e.chk_lat = chk_lat;
         if (b) qb.push_back(e);
         else   qa.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge clock); #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard drained", 64'(qa.size() + qb.size()), 64'd0);
   endtask

   initial begin
      int stray;
      reset = 1'b1;
      a_req_valid = 1'b0; a_dw = 1'b1; a_fn = '0; a_tag = '0; a_in1 = '0; a_in2 = '0; a_in3 = '0;
      b_req_valid = 1'b0; b_dw = 1'b1; b_fn = '0; b_tag = '0; b_in1 = '0; b_in2 = '0; b_in3 = '0;
      a_resp_ready = 1'b1;
      b_resp_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("reset a resp_valid", 64'(a_resp_valid), 64'd0);
      check("reset a resp_data", a_data, 64'd0);
      check("reset a resp_tag", 64'(a_rtag), 64'd0);
      check("reset a req_ready", 64'(a_req_ready), 64'd1);
      check("reset b resp_valid", 64'(b_resp_valid), 64'd0);
      check("reset b req_ready", 64'(b_req_ready), 64'd1);

      // Directed 64-bit vectors
      send(0, FN_MADDL,  1, 1,  64'h0007FFFFFFFFFFFF, 64'd2, 64'd5, 64'h0008000000000003, 1, 1);
      send(0, FN_MADDH,  1, 2,  64'h0007FFFFFFFFFFFF, 64'd2, 64'd5, 64'd6, 1, 1);
      send(0, FN_MULHU,  1, 3,  '1, '1, 64'd0, 64'hFFFFFFFFFFFFFFFE, 1, 1);
      send(0, FN_MULH,   1, 4,  '1, '1, 64'd0, 64'd0, 1, 1);
      send(0, FN_MUL,    0, 5,  64'h80000000, 64'd1, 64'd0, 64'hFFFFFFFF80000000, 1, 1);
      send(0, FN_MUL,    1, 6,  64'h80000000, 64'd1, 64'd0, 64'h0000000080000000, 1, 1);
      send(0, 6'd7,      1, 7,  '1, 64'd3, 64'd9, 64'd0, 1, 1);
      send(0, FN_MULHSU, 1, 8,  '1, 64'd2, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 1);
      send(0, FN_MADDH,  1, 9,  '1, '1, 64'h5000, 64'h1000, 1, 1);
      send(0, FN_MADDL,  0, 10, 64'd1, 64'd1, '1, 64'd0, 1, 1);
      send(0, FN_MUL,    1, 11, 64'd3, 64'd5, 64'h1234, 64'd15, 1, 1);
      send(0, FN_MULH,   1, 12, 64'h8000000000000000, 64'd2, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 1);
      send(0, 6'd63,     0, 13, 64'd7, 64'd7, 64'd7, 64'd0, 1, 1);
      idle();
      wait_drain();

      // Back-to-back stream with a three-cycle consumer stall
      fork
         begin
            for (int t = 0; t < 8; t++)
               send(0, FN_MUL, 1, 5'(t), 64'(t + 1), 64'(t + 10), 64'd0, 64'((t + 1) * (t + 10)), 0, 1);
            idle();
         end
         begin
            repeat (3) @(posedge clock);
            #1 a_resp_ready = 1'b0;
            repeat (3) @(posedge clock);
            #1 a_resp_ready = 1'b1;
         end
      join
      wait_drain();
      check("stall observed", 64'(stall_checks > 0), 64'd1);

      // Reset with two requests in flight
      mon_on = 1'b0;
      send(0, FN_MUL, 1, 20, 64'd2, 64'd3, 64'd0, 64'd6, 0, 0);
      send(0, FN_MUL, 1, 21, 64'd4, 64'd5, 64'd0, 64'd20, 0, 0);
      @(posedge clock); #1;
      a_req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("flush resp_valid", 64'(a_resp_valid), 64'd0);
      check("flush resp_data", a_data, 64'd0);
      check("flush resp_tag", 64'(a_rtag), 64'd0);
      mon_on = 1'b1;
      stray = 0;
      repeat (6) begin
         @(negedge clock);
         if (a_resp_valid) stray++;
      end
      check("no stale output after flush", 64'(stray), 64'd0);
      send(0, FN_MUL, 1, 22, 64'd6, 64'd7, 64'd0, 64'd42, 1, 1);
      idle();
      wait_drain();

      // XLEN=32, RADIX=26, STAGES=4 vectors
      send(1, FN_MADDL, 1, 1, 64'h3FFFFFF, 64'd3, 64'd1, 64'h3FFFFFE, 1, 1);
      send(1, FN_MADDH, 1, 2, 64'h3FFFFFF, 64'd3, 64'd1, 64'd3, 1, 1);
      send(1, FN_MUL,   0, 3, 64'h80000000, 64'd1, 64'd0, 64'h80000000, 1, 1);
      send(1, FN_MULH,  1, 4, 64'h80000000, 64'd2, 64'd0, 64'hFFFFFFFF, 1, 1);
      send(1, FN_MULHU, 1, 5, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd0, 64'hFFFFFFFE, 1, 1);
      send(1, 6'd7,     1, 6, 64'd9, 64'd9, 64'd9, 64'd0, 1, 1);
      idle();
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/xmul_pipe.md
Name: xmul_pipe

Overview:
- Parametrised successor of the 64-bit extended multiplier used by the reduced-radix x25519 datapath.
- Computes RISC-V MUL/MULH/MULHSU/MULHU and the radix-split multiply-accumulate ops (maddlu: low RADIX bits + in3; maddhu: product >> RADIX + in3).
- Generalised in XLEN, RADIX and pipeline depth; adds a valid/ready handshake on both sides with full backpressure.
- Sits between the core's execute stage and writeback, in place of the fixed two-stage unit.

Parameters:
- XLEN, 64, operand/result width (32 or 64).
- RADIX, 51, limb radix for MADDL/MADDH (1..XLEN-1; 26 or 29 typical for XLEN=32).
- STAGES, 2, total latency in cycles from request handshake to resp_valid (>=2).
- TAGW, 5, tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  unit can accept a request this cycle.
- req_bits_dw  in  1  1 = full XLEN, 0 = 32-bit word op (MUL only, XLEN=64 only).
- req_bits_fn  in  6  function code.
- req_bits_tag  in  TAGW  destination tag.
- req_bits_in1  in  XLEN  multiplicand.
- req_bits_in2  in  XLEN  multiplier.
- req_in3  in  XLEN  accumuland (MADDL/MADDH only).
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  result.
- resp_tag  out  TAGW  tag of the result.

Behaviour:
- Reset (synchronous): all stage valids = 0, all data/tag registers = 0. After reset: resp_valid=0, resp_data=0, resp_tag=0, req_ready=1.
- Reset asserted mid-operation flushes every in-flight request. Nothing is emitted afterwards.
- Global enable: en = !resp_valid || resp_ready.
  - req_ready = en.
  - Every pipeline register (data, tag, valid) advances only when en=1.
  - When en=0, all stages hold. Bubbles are not collapsed.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - A response is consumed when resp_valid && resp_ready.
  - With resp_ready held at 1, the result appears exactly STAGES cycles after acceptance.
  - Throughput is 1 result per cycle.
  - resp_data and resp_tag are stable while resp_valid && !resp_ready.
- Stage mapping:
  - Stage 1 registers the operands and the decoded fn.
  - Stages 2..STAGES-1 are product pipeline registers (retiming is allowed).
  - The final stage registers the muxed product and in3.
  - The accumulate add is combinational after the final register. resp_data is therefore a registered product plus a single adder.
- Decode {cmdHi, lhsSigned, rhsSigned, acc}:
  - MUL=0: 0000
  - MULH=1: 1110
  - MULHSU=2: 1100
  - MULHU=3: 1000
  - MADDL=50: 0001
  - MADDH=51: 1001
  - Any other fn: result 0, tag passed through. Never X.
- Arithmetic:
  - Operands are extended to XLEN+1 bits (sign bit = signed flag & msb); the product is 2*XLEN+1 bits.
  - MUL: prod[XLEN-1:0]. If dw=0 and XLEN=64: sign-extend prod[31:0]. dw is ignored when XLEN=32.
  - MULH/MULHSU/MULHU: prod[2*XLEN-1:XLEN].
  - MADDL: zero-extended prod[RADIX-1:0] + in3.
  - MADDH: prod[RADIX+XLEN-1:RADIX] + in3.
  - The add wraps mod 2^XLEN; there is no carry-out.
  - dw has no effect on any op other than MUL.
- Simultaneous events:
  - Accept and consume in the same cycle is legal and pipelines cleanly.
  - req_valid while req_ready=0 has no effect; the requester must hold its request.

Decomposition:
- Package xmul_pkg: FN_* codes (6-bit), decode-vector constants, TAGW default.
- Sub-module xmul_core: combinational decode, XLEN+1 signed multiply and result mux, parametrised by XLEN/RADIX.
- xmul_pipe instantiates xmul_core and generates STAGES registers with the shared enable.

Test Plan:
- MADDL, XLEN=64, RADIX=51: in1=0x7FFFFFFFFFFFF, in2=2, in3=5 -> resp_data=0x0008000000000003, exactly 2 cycles after accept.
- Same operands, MADDH -> 6. MULHU in1=in2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULH with the same operands -> 0.
- MUL dw=0: in1=0x80000000, in2=1 -> 0xFFFFFFFF80000000. dw=1 -> 0x0000000080000000. fn=7 -> 0.
- Back-to-back stream of 8 tags 0..7, resp_ready held 0 for cycles 3-5:
  - req_ready=0 during the stall.
  - resp_data and resp_tag stay stable during the stall.
  - All 8 results arrive in order with none lost or duplicated.
- Reset asserted for 1 cycle with 2 requests in flight -> resp_valid=0, resp_data=0 next cycle, no stale output afterwards.
- XLEN=32, RADIX=26, STAGES=4: MADDL in1=0x3FFFFFF, in2=3, in3=1 -> 0x3FFFFFE, 4 cycles after accept.
